// File: rtl/alu_exec_pkg.sv
// Shared types for the pipelined ALU execute unit: operation codes and the core result bundle.
// The result field is sized for the widest supported operand; narrower instances use the low bits.
package alu_exec_pkg;

  localparam int MAX_WIDTH = 64;

  typedef enum logic [3:0] {
    ALU_AND = 4'd0,
    ALU_OR  = 4'd1,
    ALU_ADD = 4'd2,
    ALU_SUB = 4'd6,
    ALU_SLT = 4'd7,
    ALU_NOR = 4'd12,
    ALU_XOR = 4'd13
  } AluCtl_t;

  typedef struct packed {
    logic [MAX_WIDTH-1:0] result;
    logic                 zero;
    logic                 ovf;
    logic                 illegal;
  } alu_res_t;

endpackage

// File: rtl/alu_exec_alu_core.sv
// Combinational ALU datapath: aluctl/a/b -> result, zero, signed overflow, illegal-code flag.
// No state, no handshake; sits between the S1 and S2 registers of alu_exec.
module alu_core
  import alu_exec_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       aluctl_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output alu_res_t         res_o
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] r;
  logic             ovf;
  logic             illegal;

  assign sum  = a_i + b_i;
  assign diff = a_i - b_i;

  always_comb begin
    r       = '0;
    ovf     = 1'b0;
    illegal = 1'b0;
    case (aluctl_i)
      ALU_AND: r = a_i & b_i;
      ALU_OR:  r = a_i | b_i;
      ALU_ADD: begin
        r   = sum;
        ovf = (a_i[MSB] == b_i[MSB]) && (sum[MSB] != a_i[MSB]);
      end
      ALU_SUB: begin
        r   = diff;
        ovf = (a_i[MSB] != b_i[MSB]) && (diff[MSB] != a_i[MSB]);
      end
      ALU_SLT: r = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      ALU_NOR: r = ~(a_i | b_i);
      ALU_XOR: r = a_i ^ b_i;
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    res_o                  = '0;
    res_o.result[MSB:0]    = r;
    res_o.zero             = (r == '0);
    res_o.ovf              = ovf;
    res_o.illegal          = illegal;
  end

endmodule

// File: rtl/alu_exec.sv
// Two-stage valid/ready ALU execute unit: S1 operand register, S2 result register; 2-cycle latency.
// in_ready drops only when both stages are full and the consumer stalls; full throughput otherwise.
module alu_exec
  import alu_exec_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       aluctl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic             illegal
);

  logic             s1_valid_q, s1_valid_d;
  logic [3:0]       s1_ctl_q, s1_ctl_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             illegal_q, illegal_d;

  logic     s2_free;
  logic     accept;
  logic     advance;
  alu_res_t core_res;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .aluctl_i (s1_ctl_q),
    .a_i      (s1_a_q),
    .b_i      (s1_b_q),
    .res_o    (core_res)
  );

  if (WIDTH < MAX_WIDTH) begin : g_unused
    logic unused_hi;
    assign unused_hi = |core_res.result[MAX_WIDTH-1:WIDTH];
  end

  assign s2_free  = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_free;
  assign accept   = in_valid && in_ready;
  assign advance  = s1_valid_q && s2_free;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_ctl_d    = s1_ctl_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    out_valid_d = out_valid_q && !out_ready;
    result_d    = result_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    illegal_d   = illegal_q;

    if (advance) begin
      s1_valid_d  = 1'b0;
      out_valid_d = 1'b1;
      result_d    = core_res.result[WIDTH-1:0];
      zero_d      = core_res.zero;
      ovf_d       = core_res.ovf;
      illegal_d   = core_res.illegal;
    end
    // A same-edge accept refills S1 after it has drained into S2.
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_ctl_d   = aluctl;
      s1_a_d     = a;
      s1_b_d     = b;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q  <= 1'b0;
      s1_ctl_q    <= '0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_ctl_q    <= s1_ctl_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      illegal_q   <= illegal_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec.sv
// Scoreboard bench for alu_exec: directed test-plan cases with hand-written expectations,
// then randomized traffic checked against an integer-arithmetic reference model.
module tb_alu_exec;

  localparam int W = 32;

  logic         clk;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   aluctl;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         ovf;
  logic         illegal;

  alu_exec #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .aluctl    (aluctl),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .ovf       (ovf),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected response packed as {result, zero, ovf, illegal}.
  typedef struct {
    logic [W+2:0] v;
    int           cyc;
    bit           lat;
  } ent_t;

  ent_t         exp_q[$];
  logic [W+2:0] hand_q[$];
  int           tests = 0;
  int           fails = 0;
  int           cyc = 0;
  int           acc_cnt = 0;
  bit           chk_lat = 0;
  logic [3:0]   ctl_tbl [7] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12, 4'd13};

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W+2:0] pack(input logic [W-1:0] r, input bit z, input bit o, input bit il);
    return {r, z, o, il};
  endfunction

  // Reference model: signed results computed in 64-bit integers, overflow = leaves the 32-bit range.
  function automatic logic [W+2:0] model(input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y);
    longint       sx;
    longint       sy;
    longint       wide;
    logic [W-1:0] r;
    bit           o;
    bit           il;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    r  = '0;
    o  = 0;
    il = 0;
    case (c)
      4'd0:  r = x & y;
      4'd1:  r = x | y;
      4'd2: begin
        wide = sx + sy;
        r = wide[W-1:0];
        o = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
      end
      4'd6: begin
        wide = sx - sy;
        r = wide[W-1:0];
        o = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
      end
      4'd7:  r = (sx < sy) ? 32'd1 : 32'd0;
      4'd12: r = ~(x | y);
      4'd13: r = x ^ y;
      default: il = 1;
    endcase
    return pack(r, (r == 0), o, il);
  endfunction

  // Monitor: pops and compares on every out-transfer, records every in-transfer.
  always @(negedge clk) begin : monitor
    ent_t e;
    if (reset_n) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_out: got result 0x%0h, expected no output (t=%0t)", result, $time);
        end else begin
          e = exp_q.pop_front();
          check("result", {result, zero, ovf, illegal}, e.v);
          if (e.lat) check("latency", cyc - e.cyc, 2);
        end
      end
      if (in_valid && in_ready) begin
        if (hand_q.size() > 0) e.v = hand_q.pop_front();
        else e.v = model(aluctl, a, b);
        e.cyc = cyc;
        e.lat = chk_lat;
        exp_q.push_back(e);
        acc_cnt++;
      end
    end
  end

  task automatic offer(input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y);
    int n;
    n = 0;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    aluctl = c;
    a = x;
    b = y;
    @(negedge clk);
    while (!in_ready) begin
      n++;
      if (n > 50) begin
        tests++;
        fails++;
        $display("FAIL send_timeout: in_ready stuck at 0, expected 1 within 50 cycles");
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic send(input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic [W+2:0] expv);
    hand_q.push_back(expv);
    offer(c, x, y);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    #1;
    check("drain_empty", exp_q.size(), 0);
    check("drain_out_valid", out_valid, 0);
  endtask

  function automatic logic [W-1:0] rnd_op();
    case ($urandom % 8)
      0: return 32'h0000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [3:0]   bp_c [4] = '{4'd2, 4'd6, 4'd13, 4'd1};
    logic [W-1:0] bp_a [4] = '{32'd1, 32'd10, 32'h0FF, 32'h100};
    logic [W-1:0] bp_b [4] = '{32'd2, 32'd3, 32'h00F, 32'h001};
    logic [W+2:0] bp_e [4];
    logic [W+2:0] snap;
    bit           have_snap;
    int           idx;
    int           n;

    bp_e[0] = pack(32'd3, 0, 0, 0);
    bp_e[1] = pack(32'd7, 0, 0, 0);
    bp_e[2] = pack(32'h0F0, 0, 0, 0);
    bp_e[3] = pack(32'h101, 0, 0, 0);

    reset_n   = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    aluctl    = '0;
    a         = '0;
    b         = '0;
    #1 reset_n = 1'b0;
    #1;
    check("reset_outputs", {out_valid, result, zero, ovf, illegal}, 0);
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    #1;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);

    // Basic ops back-to-back with the consumer always ready.
    out_ready = 1'b1;
    chk_lat = 1;
    send(4'd2,  32'd5,           32'd7,           pack(32'd12,         0, 0, 0));
    send(4'd6,  32'd7,           32'd7,           pack(32'd0,          1, 0, 0));
    send(4'd7,  32'hFFFF_FFFF,   32'd1,           pack(32'd1,          0, 0, 0));
    send(4'd12, 32'd0,           32'd0,           pack(32'hFFFF_FFFF,  0, 0, 0));
    send(4'd13, 32'h0000_F0F0,   32'h0000_FF00,   pack(32'h0000_0FF0,  0, 0, 0));
    idle();
    drain();
    chk_lat = 0;

    // Overflow corners and an illegal code followed by a legal op.
    send(4'd2,  32'h7FFF_FFFF,   32'd1,           pack(32'h8000_0000,  0, 1, 0));
    send(4'd6,  32'h8000_0000,   32'd1,           pack(32'h7FFF_FFFF,  0, 1, 0));
    send(4'd0,  32'h7FFF_FFFF,   32'd1,           pack(32'd1,          0, 0, 0));
    send(4'd0,  32'h8000_0000,   32'd1,           pack(32'd0,          1, 0, 0));
    send(4'd9,  32'd3,           32'd4,           pack(32'd0,          1, 0, 1));
    send(4'd1,  32'd3,           32'd4,           pack(32'd7,          0, 0, 0));
    idle();
    drain();

    // Backpressure: consumer stalled, four ops offered, only two may enter.
    for (int i = 0; i < 4; i++) hand_q.push_back(bp_e[i]);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    idx = 0;
    have_snap = 0;
    for (int cy = 0; cy < 6; cy++) begin
      if (cy > 0) begin
        @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      aluctl = bp_c[idx];
      a = bp_a[idx];
      b = bp_b[idx];
      @(negedge clk);
      if (in_ready) idx++;
      if (out_valid) begin
        if (!have_snap) begin
          snap = {result, zero, ovf, illegal};
          have_snap = 1;
        end else begin
          check("stall_hold", {result, zero, ovf, illegal}, snap);
        end
      end
    end
    check("stall_accepted", idx, 2);
    check("stall_in_ready", in_ready, 0);
    check("stall_out_valid", out_valid, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    offer(bp_c[2], bp_a[2], bp_b[2]);
    offer(bp_c[3], bp_a[3], bp_b[3]);
    idle();
    drain();

    // Random valid/ready traffic against the reference model.
    acc_cnt = 0;
    n = 0;
    while (acc_cnt < 10000 && n < 60000) begin
      @(posedge clk);
      #1;
      out_ready = ($urandom % 4) != 0;
      in_valid  = ($urandom % 4) != 0;
      aluctl    = (($urandom % 8) == 0) ? 4'($urandom) : ctl_tbl[$urandom % 7];
      a         = rnd_op();
      b         = rnd_op();
      n++;
    end
    check("random_ops_done", acc_cnt >= 10000, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();

    // Reset with two operations in flight.
    out_ready = 1'b0;
    send(4'd2, 32'd1, 32'd1, pack(32'd2, 0, 0, 0));
    send(4'd2, 32'd2, 32'd2, pack(32'd4, 0, 0, 0));
    @(posedge clk);
    #2;
    check("pre_reset_full", {out_valid, in_ready}, 2'b10);
    reset_n = 1'b0;
    in_valid = 1'b0;
    #1;
    check("midreset_outputs", {out_valid, result, zero, ovf, illegal}, 0);
    exp_q.delete();
    hand_q.delete();
    @(posedge clk);
    #2 reset_n = 1'b1;
    #1;
    check("post_reset_in_ready", in_ready, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_reset_no_stale", out_valid, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
